// File: rtl/gain_sched.sv
// Stereo gain scheduler: time-shares one registered gains multiplier between
// the left and right channels and ramps the applied gain one LSB at a time
// toward the programmed target (or toward zero while muted).
module gain_sched #(
    parameter int STEP_DIV  = 64,
    parameter int GAIN_INIT = 16,
    parameter int GAIN_MAX  = 31
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sample_valid,
    input  logic signed [15:0] left_in,
    input  logic signed [15:0] right_in,
    input  logic signed [5:0]  gain_target,
    input  logic               gain_load,
    input  logic               mute,
    output logic signed [15:0] mul_sample,
    output logic signed [5:0]  mul_gain,
    input  logic signed [15:0] mul_result,
    output logic signed [15:0] left_out,
    output logic signed [15:0] right_out,
    output logic               out_valid,
    output logic signed [5:0]  gain_cur,
    output logic               ramp_busy,
    output logic               overrun
);

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT, DONE} state_t;

    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0]       CNT_LAST = CW'(STEP_DIV - 1);
    localparam logic signed [5:0]   G_INIT   = 6'(GAIN_INIT);
    localparam logic signed [5:0]   G_MAX    = 6'(GAIN_MAX);
    localparam logic signed [5:0]   G_MIN    = 6'(-GAIN_MAX);

    state_t             state_q, state_d;
    logic signed [15:0] left_lat_q, left_lat_d;
    logic signed [15:0] right_lat_q, right_lat_d;
    logic signed [15:0] left_out_q, left_out_d;
    logic signed [15:0] right_out_q, right_out_d;
    logic               out_valid_q, out_valid_d;
    logic               overrun_q, overrun_d;
    logic signed [5:0]  gain_cur_q, gain_cur_d;
    logic signed [5:0]  target_q, target_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic signed [5:0]  eff_target;
    logic signed [5:0]  target_clamped;

    // Mute overrides the stored target without disturbing it.
    assign eff_target = mute ? 6'sd0 : target_q;
    assign ramp_busy  = (gain_cur_q != eff_target);

    assign mul_gain  = gain_cur_q;
    assign gain_cur  = gain_cur_q;
    assign left_out  = left_out_q;
    assign right_out = right_out_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

    // Feed the shared multiplier with whichever channel the FSM is serving.
    always_comb begin
        mul_sample = 16'sd0;
        case (state_q)
            LEFT:    mul_sample = left_lat_q;
            RIGHT:   mul_sample = right_lat_q;
            default: mul_sample = 16'sd0;
        endcase
    end

    // Clamp a newly loaded target so -32 cannot be represented as a gain.
    always_comb begin
        target_clamped = gain_target;
        if (gain_target > G_MAX) begin
            target_clamped = G_MAX;
        end else if (gain_target < G_MIN) begin
            target_clamped = G_MIN;
        end
        target_d = gain_load ? target_clamped : target_q;
    end

    // Frame sequencing, output capture and the frame-end gain ramp.
    always_comb begin
        state_d     = state_q;
        left_lat_d  = left_lat_q;
        right_lat_d = right_lat_q;
        left_out_d  = left_out_q;
        right_out_d = right_out_q;
        out_valid_d = 1'b0;
        overrun_d   = sample_valid && (state_q != IDLE);
        gain_cur_d  = gain_cur_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    left_lat_d  = left_in;
                    right_lat_d = right_in;
                    state_d     = LEFT;
                end
            end
            LEFT: begin
                state_d = RIGHT;
            end
            RIGHT: begin
                left_out_d = mul_result;
                state_d    = DONE;
            end
            DONE: begin
                right_out_d = mul_result;
                out_valid_d = 1'b1;
                state_d     = IDLE;
                if (gain_cur_q != eff_target) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d      = '0;
                        gain_cur_d = (gain_cur_q < eff_target) ? gain_cur_q + 6'sd1
                                                               : gain_cur_q - 6'sd1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All state registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            left_lat_q  <= '0;
            right_lat_q <= '0;
            left_out_q  <= '0;
            right_out_q <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            gain_cur_q  <= G_INIT;
            target_q    <= G_INIT;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            left_lat_q  <= left_lat_d;
            right_lat_q <= right_lat_d;
            left_out_q  <= left_out_d;
            right_out_q <= right_out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            gain_cur_q  <= gain_cur_d;
            target_q    <= target_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_gain_sched.sv
// Bench for gain_sched: models the external gains multiplier, drives directed
// frames and checks scaled outputs through a scoreboard queue.
module tb_gain_sched;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               sample_valid;
    logic signed [15:0] left_in, right_in;
    logic signed [5:0]  gain_target;
    logic               gain_load;
    logic               mute;
    logic signed [15:0] mul_sample;
    logic signed [5:0]  mul_gain;
    logic signed [15:0] mul_result;
    logic signed [15:0] left_out, right_out;
    logic               out_valid;
    logic signed [5:0]  gain_cur;
    logic               ramp_busy;
    logic               overrun;

    logic signed [21:0] mul_prod = '0;
    logic [31:0]        exp_q[$];

    int total_cnt = 0;
    int pass_cnt  = 0;

    gain_sched #(.STEP_DIV(4), .GAIN_INIT(16), .GAIN_MAX(31)) dut (
        .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid),
        .left_in(left_in), .right_in(right_in), .gain_target(gain_target),
        .gain_load(gain_load), .mute(mute), .mul_sample(mul_sample),
        .mul_gain(mul_gain), .mul_result(mul_result), .left_out(left_out),
        .right_out(right_out), .out_valid(out_valid), .gain_cur(gain_cur),
        .ramp_busy(ramp_busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Registered gains multiplier: result one clock after its inputs.
    always @(posedge clk) mul_prod <= mul_sample * mul_gain;
    assign mul_result = {mul_prod[21], mul_prod[19:5]};

    function automatic logic signed [15:0] scale(input int s, input int g);
        int p;
        p = s * g;
        return 16'(p >>> 5);
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One back-to-back frame: strobe, then wait until the FSM is idle again.
    task automatic applyStimulus(input int l, input int r, input int g);
        exp_q.push_back({scale(l, g), scale(r, g)});
        left_in      = 16'(l);
        right_in     = 16'(r);
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_ramp(input int n, input int l, input int r, input int g0, input int dir);
        for (int k = 0; k < n; k++) applyStimulus(l, r, g0 + dir * (k / 4));
    endtask

    task automatic load_target(input int t);
        gain_target = 6'(t);
        gain_load   = 1'b1;
        @(posedge clk); #1;
        gain_load   = 1'b0;
    endtask

    // Scoreboard monitor: every out_valid must match the oldest expected frame.
    always @(negedge clk) begin
        logic [31:0] e;
        if (reset_n && out_valid) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("[TB] FAIL unexpected_out_valid: got L=%0d R=%0d expected none", left_out, right_out);
            end else begin
                e = exp_q.pop_front();
                checkOutput("left_out", left_out, $signed(e[31:16]));
                checkOutput("right_out", right_out, $signed(e[15:0]));
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset_n = 1'b0; sample_valid = 1'b0; left_in = '0; right_in = '0;
        gain_target = '0; gain_load = 1'b0; mute = 1'b0;
        repeat (2) @(posedge clk); #1;
        checkOutput("reset_gain_cur", gain_cur, 16);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_left_out", left_out, 0);
        checkOutput("reset_mul_sample", mul_sample, 0);
        checkOutput("reset_ramp_busy", ramp_busy, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic frame with latency check at default gain.
        exp_q.push_back({scale(1000, 16), scale(-1000, 16)});
        left_in = 16'sd1000; right_in = -16'sd1000; sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        checkOutput("mul_gain", mul_gain, 16);
        repeat (2) @(posedge clk); #1;
        checkOutput("latency_early", out_valid, 0);
        @(posedge clk); #1;
        checkOutput("latency_valid", out_valid, 1);
        @(posedge clk); #1;
        checkOutput("valid_cleared", out_valid, 0);
        checkOutput("left_hold", left_out, 500);
        checkOutput("right_hold", right_out, -500);

        // Ramp 16 -> 20 with four frames per step.
        load_target(20);
        checkOutput("ramp_busy_start", ramp_busy, 1);
        run_ramp(4, 1000, -1000, 16, 1);
        checkOutput("gain_after_4", gain_cur, 17);
        run_ramp(11, 1000, -1000, 17, 1);
        checkOutput("ramp_busy_15", ramp_busy, 1);
        applyStimulus(1000, -1000, 19);
        checkOutput("gain_after_16", gain_cur, 20);
        checkOutput("ramp_busy_done", ramp_busy, 0);

        // Mute down to 10, release up to 11, mute again down to 0.
        mute = 1'b1;
        #1 checkOutput("mute_busy", ramp_busy, 1);
        run_ramp(40, 1000, -1000, 20, -1);
        checkOutput("mute_gain_10", gain_cur, 10);
        mute = 1'b0;
        run_ramp(4, 1000, -1000, 10, 1);
        checkOutput("release_gain_11", gain_cur, 11);
        mute = 1'b1;
        run_ramp(44, 1000, -1000, 11, -1);
        checkOutput("mute_gain_0", gain_cur, 0);
        checkOutput("mute_busy_done", ramp_busy, 0);
        mute = 1'b0;

        // Load -32 clamps to -31; ramp all the way there.
        load_target(-32);
        run_ramp(124, 100, -100, 0, -1);
        checkOutput("neg_gain", gain_cur, -31);
        checkOutput("neg_busy", ramp_busy, 0);
        applyStimulus(100, -100, -31);
        checkOutput("neg_left_out", left_out, -97);

        // Strobes every two clocks: odd ones are dropped and flag overrun.
        left_in = 16'sd300; right_in = -16'sd300;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) exp_q.push_back({scale(300, -31), scale(-300, -31)});
            sample_valid = 1'b1;
            @(posedge clk); #1;
            sample_valid = 1'b0;
            checkOutput("overrun", overrun, i % 2);
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk); #1;

        // Reset while in RIGHT aborts the frame.
        left_in = 16'sd2000; right_in = 16'sd2000; sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        checkOutput("abort_left_out", left_out, 0);
        checkOutput("abort_right_out", right_out, 0);
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_gain_cur", gain_cur, 16);
        repeat (2) @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clk); #1;
        applyStimulus(1000, -1000, 16);
        checkOutput("post_reset_gain", gain_cur, 16);

        for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/gain_sched.md
# gain_sched

Stereo gain scheduler that time-shares one registered `gains` multiplier between the left and right channels. It ramps the applied gain toward a programmed target, or toward zero on mute, one LSB at a time so volume changes do not click. It sits between the sample source (I2S receiver / DSP chain) and the DAC path, and owns the `gains` instance's `integer_input` and `decimal_input`.

## Interface
- `STEP_DIV`, 64: stereo frames per one-LSB gain step (≥1).
- `GAIN_INIT`, 16: signed 6-bit gain after reset (Q1.5, 32 = 1.0).
- `GAIN_MAX`, 31: clamp magnitude for loaded targets (1..31).

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `sample_valid` in 1: one-cycle strobe; `left_in`/`right_in` valid.
- `left_in` in 16 signed: left sample.
- `right_in` in 16 signed: right sample.
- `gain_target` in 6 signed: requested gain.
- `gain_load` in 1: latch `gain_target` this cycle.
- `mute` in 1: level; effective target forced to 0 while high.
- `mul_sample` out 16 signed: to `gains.integer_input`.
- `mul_gain` out 6 signed: to `gains.decimal_input`.
- `mul_result` in 16 signed: from `gains.result_output`, valid 1 clk after inputs.
- `left_out` out 16 signed: scaled left.
- `right_out` out 16 signed: scaled right.
- `out_valid` out 1: one-cycle strobe, both outputs valid.
- `gain_cur` out 6 signed: gain currently applied.
- `ramp_busy` out 1: `gain_cur` ≠ effective target.
- `overrun` out 1: one-cycle pulse, `sample_valid` arrived while busy.

## Operation
- FSM states IDLE, LEFT, RIGHT, DONE.
  - IDLE → LEFT on `sample_valid`; `left_in`/`right_in` latched.
  - LEFT → RIGHT → DONE → IDLE unconditionally.
- `mul_sample` = latched L in LEFT, latched R in RIGHT, 0 otherwise. `mul_gain` = `gain_cur` always.
- `left_out` ← `mul_result` at the edge leaving RIGHT. `right_out` ← `mul_result` and `out_valid` ← 1 at the edge leaving DONE. `out_valid` is cleared next edge.
- `left_out`/`right_out` hold their values between frames.
- `sample_valid` in LEFT/RIGHT/DONE is dropped and pulses `overrun` next cycle. A `sample_valid` in the same cycle the FSM is in IDLE (including the cycle after DONE) is accepted.
- Target register:
  - `gain_load` stores `gain_target` clamped to [−GAIN_MAX, +GAIN_MAX], so −32 becomes −GAIN_MAX.
  - Loads are accepted in any state.
  - Effective target = 0 if `mute`, else the target register.
- Ramp:
  - At the edge leaving DONE, if `gain_cur` ≠ effective target, the step counter increments.
  - When the counter reaches STEP_DIV−1 it wraps to 0 and `gain_cur` moves ±1 toward the effective target.
  - If `gain_cur` = effective target, the counter is held at 0.
  - `gain_cur` changes only at frame end, so L and R always share one gain.
- Simultaneous `gain_load` and a step: the step uses the pre-load target; the new target applies from the next frame.
- `mute` toggled mid-ramp: direction re-evaluates at the next step with no counter reset.
- `ramp_busy` is combinational from registers.

## Timing
- Reset (async, immediate) values:
  - state IDLE, counter 0
  - `gain_cur` = target = GAIN_INIT
  - `left_out` = `right_out` = 0; `out_valid` = `overrun` = 0
  - `mul_sample` = 0
- Latency: `sample_valid` sampled at edge E0 → `out_valid` high from E3 to E4.
- Maximum throughput: one frame per 4 clocks.
- Reset mid-frame aborts the frame with no `out_valid`. The first frame after release behaves as from reset.
- Arithmetic follows the `gains` format: out = {p[21], p[19:5]} with p = sample × gain (22-bit signed). The scheduler adds no rounding or saturation.

## Test plan
- Default gain 16, L=1000, R=−1000 → `out_valid` 3 clks after strobe; `left_out`=500, `right_out`=−500.
- STEP_DIV=4, load 20, 16 back-to-back frames → `gain_cur` 17 after frame 4, 20 after frame 16; `ramp_busy` falls with the last step; all frames use one gain for L/R.
- From gain 20, assert `mute` for 80 frames (STEP_DIV=4) → `gain_cur` reaches 0 after 80 frames. Release at gain 10 → ramps back toward 20.
- Load −32, GAIN_MAX=31 → target −31; L=100 → `left_out` = {p[21],p[19:5]} of 100 × gain at each step, ending at −97 (100 × −31 >> 5).
- `sample_valid` every 2 clks → every second strobe dropped; `overrun` pulses; outputs correspond only to accepted frames.
- Assert `reset_n` low in RIGHT → outputs 0 immediately, no `out_valid`. Next strobe after release completes normally with GAIN_INIT.
